// File: rtl/cp0_intc.sv
// cp0_intc: coprocessor-0 interrupt/exception controller for the single-cycle MIPS core.
// Handles NIRQ prioritised edge/level interrupt lines with per-line mask, synchronous
// exceptions, a nesting stack of {EPC, IE, IM} and vectored interrupt entry.
// The redirect decision is combinational from registered state; all state updates
// happen on the rising clock edge.
module cp0_intc #(
    parameter int          NIRQ      = 8,
    parameter int          NEST      = 4,
    parameter logic [31:0] EXC_BASE  = 32'h0000_0008,
    parameter int          VEC_SHIFT = 4
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [NIRQ-1:0] irq,
    input  logic            exc_req,
    input  logic [3:0]      exc_code,
    input  logic [31:0]     pc,
    input  logic [31:0]     npc,
    input  logic            mtc0,
    input  logic [1:0]      c0_addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic            eret,
    output logic            redirect,
    output logic [31:0]     redirect_pc,
    output logic [NIRQ-1:0] inta,
    output logic [3:0]      depth
);

    localparam logic [3:0] NEST_L   = 4'(NEST);
    localparam logic [1:0] A_STATUS = 2'd0;
    localparam logic [1:0] A_CAUSE  = 2'd1;
    localparam logic [1:0] A_EPC    = 2'd2;
    localparam logic [1:0] A_MODE   = 2'd3;

    // architectural state
    logic            ie_q, ie_d;
    logic [NIRQ-1:0] im_q, im_d;
    logic [NIRQ-1:0] mode_q, mode_d;
    logic [NIRQ-1:0] pend_q, pend_d;
    logic [NIRQ-1:0] irq_q, irq_d;
    logic [3:0]      depth_q, depth_d;
    logic [3:0]      code_q, code_d;
    logic            ov_q, ov_d;
    logic            uf_q, uf_d;

    // nesting stack
    logic [31:0]     stk_epc_q [NEST];
    logic [31:0]     stk_epc_d [NEST];
    logic            stk_ie_q  [NEST];
    logic            stk_ie_d  [NEST];
    logic [NIRQ-1:0] stk_im_q  [NEST];
    logic [NIRQ-1:0] stk_im_d  [NEST];

    // decision signals
    logic [NIRQ-1:0] req;
    logic [NIRQ-1:0] ack_vec;
    logic [NIRQ-1:0] keep_mask;
    logic [NIRQ-1:0] clr;
    logic [4:0]      k;
    logic [3:0]      top;
    logic [31:0]     epc_cur;
    logic            top_ie;
    logic [NIRQ-1:0] top_im;
    logic [31:0]     vec_pc;
    logic            can_push;
    logic            int_cond;
    logic            do_eret;
    logic            do_int;
    logic            do_mtc0;

    assign irq_d = irq;
    assign depth = depth_q;

    // Pick the highest-priority (lowest index) enabled pending line and its masks.
    always_comb begin
        req       = pend_q & im_q;
        k         = '0;
        ack_vec   = '0;
        keep_mask = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (req[i]) k = 5'(i);
        end
        for (int i = 0; i < NIRQ; i++) begin
            ack_vec[i]   = (5'(i) == k);
            keep_mask[i] = (5'(i) < k);
        end
        vec_pc = EXC_BASE + ((32'(k) + 32'd1) << VEC_SHIFT);
    end

    // Locate the stack entry visible as EPC (entry 0 when the stack is empty).
    always_comb begin
        top     = (depth_q == 4'd0) ? 4'd0 : depth_q - 4'd1;
        epc_cur = '0;
        top_ie  = 1'b0;
        top_im  = '0;
        for (int i = 0; i < NEST; i++) begin
            if (4'(i) == top) begin
                epc_cur = stk_epc_q[i];
                top_ie  = stk_ie_q[i];
                top_im  = stk_im_q[i];
            end
        end
    end

    // Arbitrate exception > eret > interrupt > mtc0 and drive the redirect outputs.
    always_comb begin
        can_push = (depth_q < NEST_L);
        int_cond = ie_q & can_push & (|req);
        do_eret  = ~exc_req & eret;
        do_int   = ~exc_req & ~eret & int_cond;
        do_mtc0  = mtc0 & ~exc_req & ~eret & ~int_cond;

        redirect = resetn & (exc_req | eret | int_cond);
        if (exc_req)       redirect_pc = EXC_BASE;
        else if (eret)     redirect_pc = epc_cur;
        else if (int_cond) redirect_pc = vec_pc;
        else               redirect_pc = EXC_BASE;
        inta = (resetn & do_int) ? ack_vec : '0;
    end

    // Next-state for pending bits, control registers and the nesting stack.
    always_comb begin
        ie_d      = ie_q;
        im_d      = im_q;
        mode_d    = mode_q;
        depth_d   = depth_q;
        code_d    = code_q;
        ov_d      = ov_q;
        uf_d      = uf_q;
        stk_epc_d = stk_epc_q;
        stk_ie_d  = stk_ie_q;
        stk_im_d  = stk_im_q;

        // edge lines latch a rising edge until taken or cleared; level lines follow irq
        clr = '0;
        if (do_int) clr = ack_vec;
        if (do_mtc0 && (c0_addr == A_CAUSE)) clr = clr | wdata[8 +: NIRQ];
        pend_d = (mode_q & ((pend_q & ~clr) | (irq & ~irq_q))) | (~mode_q & irq);

        if (exc_req) begin
            if (can_push) begin
                for (int i = 0; i < NEST; i++) begin
                    if (4'(i) == depth_q) begin
                        stk_epc_d[i] = pc;
                        stk_ie_d[i]  = ie_q;
                        stk_im_d[i]  = im_q;
                    end
                end
                depth_d = depth_q + 4'd1;
            end else begin
                ov_d = 1'b1;
            end
            ie_d   = 1'b0;
            code_d = exc_code;
        end else if (do_eret) begin
            if (depth_q != 4'd0) begin
                ie_d    = top_ie;
                im_d    = top_im;
                depth_d = depth_q - 4'd1;
            end else begin
                uf_d = 1'b1;
            end
        end else if (do_int) begin
            for (int i = 0; i < NEST; i++) begin
                if (4'(i) == depth_q) begin
                    stk_epc_d[i] = npc;
                    stk_ie_d[i]  = ie_q;
                    stk_im_d[i]  = im_q;
                end
            end
            depth_d = depth_q + 4'd1;
            im_d    = im_q & keep_mask;
            code_d  = 4'd0;
        end else if (do_mtc0) begin
            case (c0_addr)
                A_STATUS: begin
                    ie_d = wdata[0];
                    im_d = wdata[8 +: NIRQ];
                end
                A_EPC: begin
                    for (int i = 0; i < NEST; i++) begin
                        if (4'(i) == top) stk_epc_d[i] = wdata;
                    end
                end
                A_MODE:  mode_d = wdata[NIRQ-1:0];
                default: ;
            endcase
        end
    end

    // Register all state; asynchronous reset clears everything including the stack.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ie_q    <= 1'b0;
            im_q    <= '0;
            mode_q  <= '0;
            pend_q  <= '0;
            irq_q   <= '0;
            depth_q <= '0;
            code_q  <= '0;
            ov_q    <= 1'b0;
            uf_q    <= 1'b0;
            for (int i = 0; i < NEST; i++) begin
                stk_epc_q[i] <= '0;
                stk_ie_q[i]  <= 1'b0;
                stk_im_q[i]  <= '0;
            end
        end else begin
            ie_q      <= ie_d;
            im_q      <= im_d;
            mode_q    <= mode_d;
            pend_q    <= pend_d;
            irq_q     <= irq_d;
            depth_q   <= depth_d;
            code_q    <= code_d;
            ov_q      <= ov_d;
            uf_q      <= uf_d;
            stk_epc_q <= stk_epc_d;
            stk_ie_q  <= stk_ie_d;
            stk_im_q  <= stk_im_d;
        end
    end

    // mfc0 read mux; unused bits read as zero.
    always_comb begin
        rdata = '0;
        case (c0_addr)
            A_STATUS: begin
                rdata[8 +: NIRQ] = im_q;
                rdata[0]         = ie_q;
            end
            A_CAUSE: begin
                rdata[31]        = ov_q;
                rdata[30]        = uf_q;
                rdata[27:24]     = depth_q;
                rdata[8 +: NIRQ] = pend_q;
                rdata[5:2]       = code_q;
            end
            A_EPC:   rdata = epc_cur;
            default: rdata[NIRQ-1:0] = mode_q;
        endcase
    end

endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: directed vector table, hand-written corner sequences and a randomized
// run checked against a queue-based behavioural model of the controller.
module tb_cp0_intc;

    localparam int NEST = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic [7:0]  irq;
    logic        exc_req;
    logic [3:0]  exc_code;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        mtc0;
    logic [1:0]  c0_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        eret;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [7:0]  inta;
    logic [3:0]  depth;

    always #5 clock = ~clock;

    cp0_intc #(
        .NIRQ(8), .NEST(NEST), .EXC_BASE(32'h0000_0008), .VEC_SHIFT(4)
    ) dut (
        .clock(clock), .resetn(resetn), .irq(irq), .exc_req(exc_req), .exc_code(exc_code),
        .pc(pc), .npc(npc), .mtc0(mtc0), .c0_addr(c0_addr), .wdata(wdata), .rdata(rdata),
        .eret(eret), .redirect(redirect), .redirect_pc(redirect_pc), .inta(inta), .depth(depth)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic set_in(input logic [7:0] i_irq, input logic i_exc, input logic [3:0] i_code,
                          input logic [31:0] i_pc, input logic [31:0] i_npc, input logic i_mt,
                          input logic [1:0] i_addr, input logic [31:0] i_wd, input logic i_er);
        irq = i_irq; exc_req = i_exc; exc_code = i_code; pc = i_pc; npc = i_npc;
        mtc0 = i_mt; c0_addr = i_addr; wdata = i_wd; eret = i_er;
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct packed { logic [31:0] epc; logic ie; logic [7:0] im; } frame_t;
    frame_t      m_stk[$];
    logic [31:0] m_epc0;
    logic        m_ie, m_ov, m_uf;
    logic [7:0]  m_im, m_mode, m_pend, m_irqp;
    logic [3:0]  m_code;

    task automatic m_reset();
        m_stk.delete();
        m_epc0 = 0; m_ie = 0; m_ov = 0; m_uf = 0;
        m_im = 0; m_mode = 0; m_pend = 0; m_irqp = 0; m_code = 0;
    endtask

    function automatic int m_k();
        for (int i = 0; i < 8; i++) if (m_pend[i] && m_im[i]) return i;
        return -1;
    endfunction

    function automatic logic m_int_ok();
        return m_ie && (m_stk.size() < NEST) && (m_k() >= 0);
    endfunction

    function automatic logic [31:0] m_epc();
        if (m_stk.size() == 0) return m_epc0;
        return m_stk[m_stk.size() - 1].epc;
    endfunction

    task automatic m_eval(output logic r, output logic [31:0] p, output logic [7:0] a,
                          output logic [31:0] d);
        r = exc_req || eret || m_int_ok();
        p = 32'h8;
        a = 8'h00;
        if (exc_req) p = 32'h8;
        else if (eret) p = m_epc();
        else if (m_int_ok()) begin
            p = 32'h8 + 32'((m_k() + 1) * 16);
            a = 8'(1 << m_k());
        end
        case (c0_addr)
            2'd0:    d = {16'h0, m_im, 7'h0, m_ie};
            2'd1:    d = {m_ov, m_uf, 2'b00, 4'(m_stk.size()), 8'h00, m_pend, 2'b00, m_code, 2'b00};
            2'd2:    d = m_epc();
            default: d = {24'h0, m_mode};
        endcase
    endtask

    task automatic m_update();
        logic [7:0] clr;
        logic       take, wr;
        int         k;
        frame_t     f;
        k    = m_k();
        take = !exc_req && !eret && m_int_ok();
        wr   = mtc0 && !exc_req && !eret && !m_int_ok();
        clr  = 8'h00;
        if (take) clr[k] = 1'b1;
        if (wr && c0_addr == 2'd1) clr = clr | wdata[15:8];
        for (int i = 0; i < 8; i++) begin
            if (m_mode[i]) begin
                if (clr[i]) m_pend[i] = 1'b0;
                if (irq[i] && !m_irqp[i]) m_pend[i] = 1'b1;
            end else begin
                m_pend[i] = irq[i];
            end
        end
        m_irqp = irq;
        if (exc_req) begin
            if (m_stk.size() < NEST) begin
                f.epc = pc; f.ie = m_ie; f.im = m_im;
                m_stk.push_back(f);
            end else m_ov = 1'b1;
            m_ie = 1'b0;
            m_code = exc_code;
        end else if (eret) begin
            if (m_stk.size() > 0) begin
                f = m_stk.pop_back();
                m_ie = f.ie; m_im = f.im;
            end else m_uf = 1'b1;
        end else if (take) begin
            f.epc = npc; f.ie = m_ie; f.im = m_im;
            m_stk.push_back(f);
            m_im = m_im & 8'((1 << k) - 1);
            m_code = 4'h0;
        end else if (wr) begin
            case (c0_addr)
                2'd0: begin m_ie = wdata[0]; m_im = wdata[15:8]; end
                2'd2: begin
                    if (m_stk.size() == 0) m_epc0 = wdata;
                    else begin
                        f = m_stk[m_stk.size() - 1];
                        f.epc = wdata;
                        m_stk[m_stk.size() - 1] = f;
                    end
                end
                2'd3: m_mode = wdata[7:0];
                default: ;
            endcase
        end
        if (m_stk.size() > 0) m_epc0 = m_stk[0].epc;
    endtask

    task automatic do_reset();
        set_in(8'h00, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0);
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        m_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [7:0] irq; logic exc; logic [3:0] code; logic [31:0] pc; logic [31:0] npc;
        logic mt; logic [1:0] addr; logic [31:0] wd; logic er;
        logic red; logic [31:0] rpc; logic [7:0] ack; logic [3:0] dep; logic [31:0] rd;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] i_irq, input logic [31:0] i_npc, input logic i_mt,
                                input logic [1:0] i_addr, input logic [31:0] i_wd, input logic i_er,
                                input logic e_red, input logic [31:0] e_rpc, input logic [7:0] e_ack,
                                input logic [3:0] e_dep, input logic [31:0] e_rd);
        vec_t v;
        v.irq = i_irq; v.exc = 1'b0; v.code = 4'h0; v.pc = 32'h0; v.npc = i_npc;
        v.mt = i_mt; v.addr = i_addr; v.wd = i_wd; v.er = i_er;
        v.red = e_red; v.rpc = e_rpc; v.ack = e_ack; v.dep = e_dep; v.rd = e_rd;
        return v;
    endfunction

    vec_t        tbl[14];
    logic        e_red;
    logic [31:0] e_rpc, e_rd;
    logic [7:0]  e_ack, ri;

    initial begin
        tbl[0]  = mk(8'h00, 32'h00, 1'b1, 2'd3, 32'h000, 1'b0, 1'b0, 32'h00, 8'h00, 4'd0, 32'h0000_0000);
        tbl[1]  = mk(8'h00, 32'h00, 1'b1, 2'd0, 32'h301, 1'b0, 1'b0, 32'h00, 8'h00, 4'd0, 32'h0000_0000);
        tbl[2]  = mk(8'h02, 32'h40, 1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 32'h00, 8'h00, 4'd0, 32'h0000_0301);
        tbl[3]  = mk(8'h02, 32'h40, 1'b0, 2'd1, 32'h000, 1'b0, 1'b1, 32'h28, 8'h02, 4'd0, 32'h0000_0200);
        tbl[4]  = mk(8'h02, 32'h44, 1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 32'h00, 8'h00, 4'd1, 32'h0000_0101);
        tbl[5]  = mk(8'h0A, 32'h48, 1'b0, 2'd2, 32'h000, 1'b0, 1'b0, 32'h00, 8'h00, 4'd1, 32'h0000_0040);
        tbl[6]  = mk(8'h0A, 32'h4C, 1'b0, 2'd1, 32'h000, 1'b0, 1'b0, 32'h00, 8'h00, 4'd1, 32'h0100_0A00);
        tbl[7]  = mk(8'h0B, 32'h80, 1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 32'h00, 8'h00, 4'd1, 32'h0000_0101);
        tbl[8]  = mk(8'h0B, 32'h80, 1'b0, 2'd1, 32'h000, 1'b0, 1'b1, 32'h18, 8'h01, 4'd1, 32'h0100_0B00);
        tbl[9]  = mk(8'h0A, 32'h84, 1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 32'h00, 8'h00, 4'd2, 32'h0000_0001);
        tbl[10] = mk(8'h00, 32'h88, 1'b0, 2'd2, 32'h000, 1'b1, 1'b1, 32'h80, 8'h00, 4'd2, 32'h0000_0080);
        tbl[11] = mk(8'h00, 32'h8C, 1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 32'h00, 8'h00, 4'd1, 32'h0000_0101);
        tbl[12] = mk(8'h00, 32'h90, 1'b0, 2'd2, 32'h000, 1'b1, 1'b1, 32'h40, 8'h00, 4'd1, 32'h0000_0040);
        tbl[13] = mk(8'h00, 32'h94, 1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 32'h00, 8'h00, 4'd0, 32'h0000_0301);

        // reset asserted mid-handler with two frames stacked
        do_reset();
        set_in(8'h00, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 2'd0, 32'h301, 1'b0);
        @(negedge clock);
        set_in(8'h00, 1'b1, 4'h1, 32'h200, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0);
        repeat (2) @(negedge clock);
        #1 chk("rst_pre_depth", 32'(depth), 32'd2);
        chk("rst_pre_redirect", 32'(redirect), 32'd1);
        #2 resetn = 1'b0;
        #1 chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_status", rdata, 32'h0);
        chk("rst_inta", 32'(inta), 32'd0);
        @(negedge clock);
        set_in(8'h00, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0);
        resetn = 1'b1;
        #1 chk("rel_status", rdata, 32'h0);
        chk("rel_redirect", 32'(redirect), 32'd0);
        @(negedge clock);
        c0_addr = 2'd1;
        #1 chk("rel_cause", rdata, 32'h0);
        chk("rel_depth", 32'(depth), 32'd0);

        // single, nested and blocked interrupts with two erets
        do_reset();
        for (int r = 0; r < 14; r++) begin
            set_in(tbl[r].irq, tbl[r].exc, tbl[r].code, tbl[r].pc, tbl[r].npc, tbl[r].mt,
                   tbl[r].addr, tbl[r].wd, tbl[r].er);
            #1;
            chk($sformatf("tbl%0d_redirect", r), 32'(redirect), 32'(tbl[r].red));
            if (tbl[r].red) chk($sformatf("tbl%0d_redirect_pc", r), redirect_pc, tbl[r].rpc);
            chk($sformatf("tbl%0d_inta", r), 32'(inta), 32'(tbl[r].ack));
            chk($sformatf("tbl%0d_depth", r), 32'(depth), 32'(tbl[r].dep));
            chk($sformatf("tbl%0d_rdata", r), rdata, tbl[r].rd);
            @(negedge clock);
        end

        // exception beats an interrupt that is ready in the same cycle
        set_in(8'h01, 1'b0, 4'h0, 32'h0, 32'h500, 1'b0, 2'd0, 32'h0, 1'b0);
        #1 chk("prec_pre_redirect", 32'(redirect), 32'd0);
        @(negedge clock);
        set_in(8'h01, 1'b1, 4'hC, 32'h100, 32'h500, 1'b0, 2'd0, 32'h0, 1'b0);
        #1 chk("prec_redirect", 32'(redirect), 32'd1);
        chk("prec_redirect_pc", redirect_pc, 32'h8);
        chk("prec_inta", 32'(inta), 32'd0);
        @(negedge clock);
        set_in(8'h01, 1'b0, 4'h0, 32'h0, 32'h504, 1'b0, 2'd1, 32'h0, 1'b0);
        #1 chk("prec_code", 32'(rdata[5:2]), 32'hC);
        chk("prec_depth", 32'(depth), 32'd1);
        chk("prec_blocked", 32'(redirect), 32'd0);
        @(negedge clock);
        c0_addr = 2'd2;
        #1 chk("prec_epc", rdata, 32'h100);
        @(negedge clock);
        c0_addr = 2'd0;
        #1 chk("prec_status", rdata, 32'h300);
        chk("prec_blocked2", 32'(redirect), 32'd0);
        @(negedge clock);

        // stack overflow and underflow
        do_reset();
        set_in(8'h00, 1'b1, 4'h3, 32'h1000, 32'h0, 1'b0, 2'd1, 32'h0, 1'b0);
        repeat (4) @(negedge clock);
        #1 chk("ovf_depth4", 32'(depth), 32'd4);
        chk("ovf_redirect", 32'(redirect), 32'd1);
        chk("ovf_redirect_pc", redirect_pc, 32'h8);
        @(negedge clock);
        set_in(8'h00, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd1, 32'h0, 1'b0);
        #1 chk("ovf_depth_hold", 32'(depth), 32'd4);
        chk("ovf_flag", 32'(rdata[31]), 32'd1);
        @(negedge clock);
        eret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("pop%0d_redirect", i), 32'(redirect), 32'd1);
            @(negedge clock);
        end
        #1 chk("unf_depth0", 32'(depth), 32'd0);
        chk("unf_redirect", 32'(redirect), 32'd1);
        chk("unf_flag_before", 32'(rdata[30]), 32'd0);
        @(negedge clock);
        eret = 1'b0;
        #1 chk("unf_flag", 32'(rdata[30]), 32'd1);
        chk("unf_depth", 32'(depth), 32'd0);
        chk("ovf_sticky", 32'(rdata[31]), 32'd1);

        // edge pending with write-1-to-clear; level line ignores it
        do_reset();
        set_in(8'h00, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 2'd3, 32'h04, 1'b0);
        @(negedge clock);
        set_in(8'h0C, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 2'd1, 32'h0, 1'b0);
        @(negedge clock);
        irq = 8'h08;
        #1 chk("w1c_set", rdata, 32'h0000_0C00);
        @(negedge clock);
        mtc0 = 1'b1; wdata = 32'h0000_0C00;
        #1 chk("w1c_held", rdata, 32'h0000_0C00);
        @(negedge clock);
        mtc0 = 1'b0;
        #1 chk("w1c_cleared", rdata, 32'h0000_0800);
        chk("w1c_redirect", 32'(redirect), 32'd0);
        @(negedge clock);

        // randomized run against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            ri = irq;
            if ($urandom_range(0, 3) == 0) ri = ri ^ 8'($urandom);
            set_in(ri, $urandom_range(0, 19) == 0, 4'($urandom), $urandom, $urandom,
                   $urandom_range(0, 4) == 0, 2'($urandom), $urandom, $urandom_range(0, 9) == 0);
            #1;
            m_eval(e_red, e_rpc, e_ack, e_rd);
            chk("rnd_redirect", 32'(redirect), 32'(e_red));
            if (e_red) chk("rnd_redirect_pc", redirect_pc, e_rpc);
            chk("rnd_inta", 32'(inta), 32'(e_ack));
            chk("rnd_depth", 32'(depth), 32'(m_stk.size()));
            chk("rnd_rdata", rdata, e_rd);
            m_update();
            @(negedge clock);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
